// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - behavioural DRAM responder: write-data FIFO, masked commits, fixed-latency reads
module dram_responder #(
   parameter int DDRDWidth   = 512,
   parameter int DDRAWidth   = 28,
   parameter int DDRCWidth   = 3,
   parameter int MemAW       = 10,
   parameter int AddrShift   = 3,
   parameter int ReadLatency = 8,
   parameter int WDFDepth    = 4
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic [DDRAWidth-1:0]   DRAMAddress,
   input  logic [DDRCWidth-1:0]   DRAMCommand,
   input  logic                   DRAMCommandValid,
   output logic                   DRAMCommandReady,
   input  logic [DDRDWidth-1:0]   DRAMWriteData,
   input  logic [DDRDWidth/8-1:0] DRAMWriteMask,
   input  logic                   DRAMWriteDataValid,
   output logic                   DRAMWriteDataReady,
   output logic [DDRDWidth-1:0]   DRAMReadData,
   output logic                   DRAMReadDataValid,
   output logic                   Error
);
   localparam int NB  = DDRDWidth / 8;
   localparam int FAW = $clog2(WDFDepth);
   localparam int PS  = ReadLatency - 1;

   typedef enum logic {IDLE, WAIT_WDATA} state_t;

   state_t               r_state;
   logic                 r_live;
   logic [MemAW-1:0]     r_wait_idx;
   logic [DDRDWidth-1:0] r_mem [2**MemAW];
   logic [DDRDWidth-1:0] r_wdf_data [WDFDepth];
   logic [NB-1:0]        r_wdf_mask [WDFDepth];
   logic [FAW:0]         r_wr_ptr;
   logic [FAW:0]         r_rd_ptr;
   logic [PS-1:0]        r_pipe_vld;
   logic [DDRDWidth-1:0] r_pipe_dat [PS];
   logic [DDRDWidth-1:0] r_rdata;
   logic                 r_rvalid;
   logic                 r_error;

   logic [MemAW-1:0]     w_idx;
   logic [MemAW-1:0]     w_commit_idx;
   logic                 w_cmd_fire;
   logic                 w_is_wr;
   logic                 w_is_rd;
   logic                 w_rd_fire;
   logic                 w_fifo_empty;
   logic                 w_fifo_full;
   logic                 w_push;
   logic                 w_commit;
   logic [DDRDWidth-1:0] w_head_data;
   logic [NB-1:0]        w_head_mask;
   logic                 w_addr_unused;

   // Upper address bits alias onto the same word; low bits select within a burst.
   assign w_idx         = DRAMAddress[AddrShift +: MemAW];
   assign w_addr_unused = ^{DRAMAddress[DDRAWidth-1:AddrShift+MemAW], DRAMAddress[AddrShift-1:0]};

   assign DRAMCommandReady   = r_live && (r_state == IDLE);
   assign DRAMWriteDataReady = r_live && !w_fifo_full;
   assign DRAMReadData       = r_rdata;
   assign DRAMReadDataValid  = r_rvalid;
   assign Error              = r_error;

   assign w_cmd_fire   = DRAMCommandValid && DRAMCommandReady;
   assign w_is_wr      = (DRAMCommand == DDRCWidth'(0));
   assign w_is_rd      = (DRAMCommand == DDRCWidth'(1));
   assign w_rd_fire    = w_cmd_fire && w_is_rd;
   assign w_push       = DRAMWriteDataValid && DRAMWriteDataReady;
   assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
   assign w_fifo_full  = (r_wr_ptr[FAW] != r_rd_ptr[FAW]) && (r_wr_ptr[FAW-1:0] == r_rd_ptr[FAW-1:0]);
   assign w_head_data  = r_wdf_data[r_rd_ptr[FAW-1:0]];
   assign w_head_mask  = r_wdf_mask[r_rd_ptr[FAW-1:0]];
   assign w_commit_idx = (r_state == IDLE) ? w_idx : r_wait_idx;
   assign w_commit     = !Reset && !w_fifo_empty &&
                         (((r_state == IDLE) && w_cmd_fire && w_is_wr) || (r_state == WAIT_WDATA));

   // Storage without reset: backing store survives Reset, FIFO/pipe payloads are qualified by pointers/valids.
   always_ff @(posedge Clock) begin
      if (w_commit) begin
         for (int b = 0; b < NB; b++) begin
            if (!w_head_mask[b]) r_mem[w_commit_idx][b*8 +: 8] <= w_head_data[b*8 +: 8];
         end
      end
      if (w_push) begin
         r_wdf_data[r_wr_ptr[FAW-1:0]] <= DRAMWriteData;
         r_wdf_mask[r_wr_ptr[FAW-1:0]] <= DRAMWriteMask;
      end
      // Sampling at accept fixes the data to command order regardless of later writes.
      if (w_rd_fire) r_pipe_dat[0] <= r_mem[w_idx];
      for (int i = 1; i < PS; i++) r_pipe_dat[i] <= r_pipe_dat[i-1];
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_live     <= 1'b0;
         r_wait_idx <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_pipe_vld <= '0;
         r_rvalid   <= 1'b0;
         r_rdata    <= '0;
         r_error    <= 1'b0;
      end else begin
         r_live <= 1'b1;
         if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_commit) r_rd_ptr <= r_rd_ptr + 1'b1;
         case (r_state)
            IDLE: begin
               if (w_cmd_fire) begin
                  if (w_is_wr) begin
                     if (w_fifo_empty) begin
                        r_wait_idx <= w_idx;
                        r_state    <= WAIT_WDATA;
                     end
                  end else if (!w_is_rd) begin
                     r_error <= 1'b1;
                  end
               end
            end
            WAIT_WDATA: begin
               if (!w_fifo_empty) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
         r_pipe_vld[0] <= w_rd_fire;
         for (int i = 1; i < PS; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
         r_rvalid <= r_pipe_vld[PS-1];
         if (r_pipe_vld[PS-1]) r_rdata <= r_pipe_dat[PS-1];
      end
   end
endmodule

// File: tb/tb_dram_responder.sv
// tb/tb_dram_responder.sv - randomized self-checking bench for dram_responder
module tb_dram_responder;
   localparam int DW = 512;
   localparam int AW = 28;
   localparam int CW = 3;
   localparam int NB = 64;
   localparam int L  = 8;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic [AW-1:0] DRAMAddress = '0;
   logic [CW-1:0] DRAMCommand = '0;
   logic          DRAMCommandValid = 1'b0;
   logic          DRAMCommandReady;
   logic [DW-1:0] DRAMWriteData = '0;
   logic [NB-1:0] DRAMWriteMask = '0;
   logic          DRAMWriteDataValid = 1'b0;
   logic          DRAMWriteDataReady;
   logic [DW-1:0] DRAMReadData;
   logic          DRAMReadDataValid;
   logic          Error;

   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;
   int n_to = 0;
   int cap_cyc[$];
   int exp_cyc[$];
   logic [DW-1:0] cap_dat[$];
   logic [DW-1:0] exp_dat[$];
   logic [DW-1:0] m_mem [1024];

   dram_responder dut (
      .Clock(Clock), .Reset(Reset), .DRAMAddress(DRAMAddress), .DRAMCommand(DRAMCommand),
      .DRAMCommandValid(DRAMCommandValid), .DRAMCommandReady(DRAMCommandReady),
      .DRAMWriteData(DRAMWriteData), .DRAMWriteMask(DRAMWriteMask),
      .DRAMWriteDataValid(DRAMWriteDataValid), .DRAMWriteDataReady(DRAMWriteDataReady),
      .DRAMReadData(DRAMReadData), .DRAMReadDataValid(DRAMReadDataValid), .Error(Error)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;
   always @(negedge Clock) begin
      if (DRAMReadDataValid) begin
         cap_cyc.push_back(cyc);
         cap_dat.push_back(DRAMReadData);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r;
      for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [AW-1:0] mk_addr(input int idx);
      logic [AW-1:0] a;
      a = AW'($urandom);
      a[12:3] = 10'(idx);
      return a;
   endfunction

   // Reference store: a byte is written only where its mask bit is 0.
   function automatic void m_write(input int idx, input logic [DW-1:0] d, input logic [NB-1:0] m);
      for (int b = 0; b < NB; b++) if (!m[b]) m_mem[idx][b*8 +: 8] = d[b*8 +: 8];
   endfunction

   task automatic drive_cmd(input logic [CW-1:0] c, input logic [AW-1:0] a, output int pc);
      bit ok;
      ok = 1'b0;
      pc = 0;
      DRAMCommand = c;
      DRAMAddress = a;
      DRAMCommandValid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         pc = cyc;
         ok = DRAMCommandReady;
         step();
      end
      DRAMCommandValid = 1'b0;
      if (!ok) n_to++;
   endtask

   task automatic drive_data(input logic [DW-1:0] d, input logic [NB-1:0] m);
      bit ok;
      ok = 1'b0;
      DRAMWriteData = d;
      DRAMWriteMask = m;
      DRAMWriteDataValid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         ok = DRAMWriteDataReady;
         step();
      end
      DRAMWriteDataValid = 1'b0;
      if (!ok) n_to++;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] m);
      int pc;
      drive_data(d, m);
      drive_cmd(3'b000, a, pc);
      m_write(int'(a[12:3]), d, m);
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      int pc;
      drive_cmd(3'b001, a, pc);
      exp_cyc.push_back(pc + L);
      exp_dat.push_back(m_mem[a[12:3]]);
   endtask

   task automatic clear_q();
      cap_cyc.delete();
      cap_dat.delete();
      exp_cyc.delete();
      exp_dat.delete();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) step();
      n_total++; if (DRAMCommandReady !== 1'b0) $display("FAIL rst_cmd_ready: got %b expected 0", DRAMCommandReady); else n_pass++;
      n_total++; if (DRAMWriteDataReady !== 1'b0) $display("FAIL rst_wd_ready: got %b expected 0", DRAMWriteDataReady); else n_pass++;
      n_total++; if (DRAMReadDataValid !== 1'b0) $display("FAIL rst_rd_valid: got %b expected 0", DRAMReadDataValid); else n_pass++;
      n_total++; if (Error !== 1'b0) $display("FAIL rst_error: got %b expected 0", Error); else n_pass++;
      n_total++; if (DRAMReadData !== '0) $display("FAIL rst_rd_data: got %h expected 0", DRAMReadData); else n_pass++;
      Reset = 1'b0;
      step();
      n_total++; if (DRAMCommandReady !== 1'b1) $display("FAIL post_rst_cmd_ready: got %b expected 1", DRAMCommandReady); else n_pass++;
      n_total++; if (DRAMWriteDataReady !== 1'b1) $display("FAIL post_rst_wd_ready: got %b expected 1", DRAMWriteDataReady); else n_pass++;
   endtask

   task automatic test_write_read();
      int to0 = n_to;
      clear_q();
      do_write(28'h40, {64{8'hA5}}, '0);
      do_read(28'h40);
      repeat (L + 4) step();
      n_total++;
      if (cap_cyc.size() !== 1) $display("FAIL wr_rd_pulses: got %0d expected 1", cap_cyc.size());
      else begin
         n_pass++;
         n_total++;
         if (cap_cyc[0] !== exp_cyc[0] || cap_dat[0] !== {64{8'hA5}})
            $display("FAIL wr_rd_data: got cyc %0d data %h expected cyc %0d data %h", cap_cyc[0], cap_dat[0], exp_cyc[0], {64{8'hA5}});
         else n_pass++;
      end
      n_total++; if (DRAMReadData !== {64{8'hA5}}) $display("FAIL rd_hold: got %h expected %h", DRAMReadData, {64{8'hA5}}); else n_pass++;
      n_total++; if (n_to !== to0) $display("FAIL wr_rd_timeout: got %0d expected %0d", n_to, to0); else n_pass++;
   endtask

   task automatic test_wait_wdata();
      int pc;
      int lo = 0;
      int to0 = n_to;
      logic [DW-1:0] d = rnd_data();
      clear_q();
      drive_cmd(3'b000, 28'h80, pc);
      for (int i = 0; i < 5; i++) begin
         if (DRAMCommandReady === 1'b0) lo++;
         step();
      end
      n_total++; if (lo !== 5) $display("FAIL wait_ready_low: got %0d low cycles expected 5", lo); else n_pass++;
      drive_data(d, '0);
      n_total++; if (DRAMCommandReady !== 1'b0) $display("FAIL wait_commit_edge: got %b expected 0", DRAMCommandReady); else n_pass++;
      step();
      n_total++; if (DRAMCommandReady !== 1'b1) $display("FAIL wait_return_idle: got %b expected 1", DRAMCommandReady); else n_pass++;
      m_write(16, d, '0);
      do_read(28'h80);
      repeat (L + 3) step();
      n_total++;
      if (cap_cyc.size() !== exp_cyc.size()) $display("FAIL wait_rd_pulses: got %0d expected %0d", cap_cyc.size(), exp_cyc.size());
      else begin
         n_pass++;
         foreach (exp_cyc[i]) begin
            n_total++;
            if (cap_cyc[i] !== exp_cyc[i] || cap_dat[i] !== exp_dat[i])
               $display("FAIL wait_rd[%0d]: got cyc %0d data %h expected cyc %0d data %h", i, cap_cyc[i], cap_dat[i], exp_cyc[i], exp_dat[i]);
            else n_pass++;
         end
      end
      n_total++; if (n_to !== to0) $display("FAIL wait_timeout: got %0d expected %0d", n_to, to0); else n_pass++;
   endtask

   task automatic test_fifo_full();
      int pc;
      int rdy = 0;
      int to0 = n_to;
      logic [DW-1:0] ds [4];
      clear_q();
      DRAMWriteMask = '0;
      DRAMWriteDataValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ds[i] = rnd_data();
         DRAMWriteData = ds[i];
         if (DRAMWriteDataReady === 1'b1) rdy++;
         step();
      end
      DRAMWriteDataValid = 1'b0;
      n_total++; if (rdy !== 4) $display("FAIL fifo_accepts: got %0d expected 4", rdy); else n_pass++;
      n_total++; if (DRAMWriteDataReady !== 1'b0) $display("FAIL fifo_full_ready: got %b expected 0", DRAMWriteDataReady); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         drive_cmd(3'b000, AW'(i * 8), pc);
         m_write(i, ds[i], '0);
      end
      n_total++; if (DRAMWriteDataReady !== 1'b1) $display("FAIL fifo_drained_ready: got %b expected 1", DRAMWriteDataReady); else n_pass++;
      for (int i = 0; i < 4; i++) do_read(AW'(i * 8));
      repeat (L + 3) step();
      n_total++;
      if (cap_cyc.size() !== exp_cyc.size()) $display("FAIL fifo_rd_pulses: got %0d expected %0d", cap_cyc.size(), exp_cyc.size());
      else begin
         n_pass++;
         foreach (exp_cyc[i]) begin
            n_total++;
            if (cap_cyc[i] !== exp_cyc[i] || cap_dat[i] !== ds[i])
               $display("FAIL fifo_order[%0d]: got cyc %0d data %h expected cyc %0d data %h", i, cap_cyc[i], cap_dat[i], exp_cyc[i], ds[i]);
            else n_pass++;
         end
      end
      n_total++; if (n_to !== to0) $display("FAIL fifo_timeout: got %0d expected %0d", n_to, to0); else n_pass++;
   endtask

   task automatic test_mask();
      int to0 = n_to;
      logic [DW-1:0] want = {{63{8'hFF}}, 8'h00};
      logic [DW-1:0] got;
      clear_q();
      do_write(28'h100, '1, '0);
      do_write(28'h100, '0, 64'hFFFF_FFFF_FFFF_FFFE);
      do_read(28'h100);
      do_write(28'h100, rnd_data(), '1);
      do_read(28'h100);
      repeat (L + 3) step();
      got = (cap_dat.size() > 0) ? cap_dat[0] : 'x;
      n_total++; if (got !== want) $display("FAIL mask_byte0: got %h expected %h", got, want); else n_pass++;
      got = (cap_dat.size() > 1) ? cap_dat[1] : 'x;
      n_total++; if (got !== want) $display("FAIL mask_all_ones: got %h expected %h", got, want); else n_pass++;
      n_total++;
      if (cap_cyc.size() !== 2 || cap_cyc[0] !== exp_cyc[0] || cap_cyc[1] !== exp_cyc[1])
         $display("FAIL mask_timing: got %0d pulses expected 2 at cycles %0d,%0d", cap_cyc.size(), exp_cyc[0], exp_cyc[1]);
      else n_pass++;
      n_total++; if (n_to !== to0) $display("FAIL mask_timeout: got %0d expected %0d", n_to, to0); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int rdy = 0;
      clear_q();
      DRAMCommand = 3'b001;
      DRAMCommandValid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         DRAMAddress = mk_addr(i % 4);
         if (DRAMCommandReady === 1'b1) rdy++;
         exp_cyc.push_back(cyc + L);
         exp_dat.push_back(m_mem[i % 4]);
         step();
      end
      DRAMCommandValid = 1'b0;
      n_total++; if (rdy !== 8) $display("FAIL b2b_accepts: got %0d expected 8", rdy); else n_pass++;
      repeat (L + 3) step();
      n_total++;
      if (cap_cyc.size() !== 8) $display("FAIL b2b_pulses: got %0d expected 8", cap_cyc.size());
      else begin
         n_pass++;
         foreach (exp_cyc[i]) begin
            n_total++;
            if (cap_cyc[i] !== exp_cyc[i] || cap_dat[i] !== exp_dat[i])
               $display("FAIL b2b[%0d]: got cyc %0d data %h expected cyc %0d data %h", i, cap_cyc[i], cap_dat[i], exp_cyc[i], exp_dat[i]);
            else n_pass++;
         end
      end
      clear_q();
      DRAMCommandValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         DRAMAddress = mk_addr(i);
         step();
      end
      DRAMCommandValid = 1'b0;
      Reset = 1'b1;
      repeat (2) step();
      Reset = 1'b0;
      repeat (L + 4) step();
      n_total++; if (cap_cyc.size() !== 0) $display("FAIL b2b_reset_flush: got %0d pulses expected 0", cap_cyc.size()); else n_pass++;
   endtask

   task automatic test_reset_midop();
      int pc;
      int to0 = n_to;
      logic [DW-1:0] d1 = rnd_data();
      logic [DW-1:0] d2 = rnd_data();
      clear_q();
      drive_data(d1, '0);
      Reset = 1'b1;
      repeat (2) step();
      Reset = 1'b0;
      step();
      drive_cmd(3'b000, 28'h200, pc);
      n_total++; if (DRAMCommandReady !== 1'b0) $display("FAIL midop_fifo_flushed: got ready %b expected 0", DRAMCommandReady); else n_pass++;
      drive_data(d2, '0);
      step();
      m_write(64, d2, '0);
      do_read(28'h200);
      do_read(28'h40);
      repeat (L + 3) step();
      n_total++;
      if (cap_cyc.size() !== 2) $display("FAIL midop_pulses: got %0d expected 2", cap_cyc.size());
      else begin
         n_pass++;
         foreach (exp_cyc[i]) begin
            n_total++;
            if (cap_cyc[i] !== exp_cyc[i] || cap_dat[i] !== exp_dat[i])
               $display("FAIL midop_rd[%0d]: got cyc %0d data %h expected cyc %0d data %h", i, cap_cyc[i], cap_dat[i], exp_cyc[i], exp_dat[i]);
            else n_pass++;
         end
      end
      n_total++; if (n_to !== to0) $display("FAIL midop_timeout: got %0d expected %0d", n_to, to0); else n_pass++;
   endtask

   task automatic test_illegal();
      int pc;
      int to0 = n_to;
      clear_q();
      drive_cmd(3'b111, 28'h40, pc);
      n_total++; if (Error !== 1'b1) $display("FAIL illegal_error: got %b expected 1", Error); else n_pass++;
      n_total++; if (DRAMCommandReady !== 1'b1) $display("FAIL illegal_stays_idle: got %b expected 1", DRAMCommandReady); else n_pass++;
      drive_cmd(CW'($urandom_range(2, 6)), mk_addr(8), pc);
      repeat (3) step();
      n_total++; if (Error !== 1'b1) $display("FAIL illegal_sticky: got %b expected 1", Error); else n_pass++;
      do_read(28'h40);
      repeat (L + 3) step();
      n_total++;
      if (cap_dat.size() !== 1 || cap_dat[0] !== {64{8'hA5}} || cap_cyc[0] !== exp_cyc[0])
         $display("FAIL illegal_mem_unchanged: got %0d pulses, expected one at cyc %0d with %h", cap_dat.size(), exp_cyc[0], {64{8'hA5}});
      else n_pass++;
      n_total++; if (n_to !== to0) $display("FAIL illegal_accept_timeout: got %0d expected %0d", n_to, to0); else n_pass++;
      Reset = 1'b1;
      repeat (2) step();
      n_total++; if (Error !== 1'b0) $display("FAIL illegal_reset_clear: got %b expected 0", Error); else n_pass++;
      Reset = 1'b0;
      step();
   endtask

   task automatic test_random();
      int words [8] = '{0, 1, 2, 3, 4, 1021, 1022, 1023};
      int to0 = n_to;
      for (int i = 0; i < 8; i++) do_write(mk_addr(words[i]), rnd_data(), '0);
      clear_q();
      for (int n = 0; n < 80; n++) begin
         int idx = words[$urandom_range(0, 7)];
         logic [AW-1:0] a = mk_addr(idx);
         if ($urandom_range(0, 2) == 0) begin
            do_read(a);
         end else begin
            logic [DW-1:0] d = rnd_data();
            logic [NB-1:0] m;
            int dl_d = $urandom_range(0, 3);
            int dl_c = $urandom_range(0, 3);
            int pc;
            case ($urandom_range(0, 3))
               0:       m = '0;
               1:       m = '1;
               default: m = {$urandom, $urandom};
            endcase
            fork
               begin repeat (dl_d) step(); drive_data(d, m); end
               begin repeat (dl_c) step(); drive_cmd(3'b000, a, pc); end
            join
            m_write(idx, d, m);
         end
      end
      repeat (L + 4) step();
      n_total++;
      if (cap_cyc.size() !== exp_cyc.size()) $display("FAIL rand_pulses: got %0d expected %0d", cap_cyc.size(), exp_cyc.size());
      else begin
         n_pass++;
         foreach (exp_cyc[i]) begin
            n_total++;
            if (cap_cyc[i] !== exp_cyc[i] || cap_dat[i] !== exp_dat[i])
               $display("FAIL rand_rd[%0d]: got cyc %0d data %h expected cyc %0d data %h", i, cap_cyc[i], cap_dat[i], exp_cyc[i], exp_dat[i]);
            else n_pass++;
         end
      end
      n_total++; if (n_to !== to0) $display("FAIL rand_timeout: got %0d expected %0d", n_to, to0); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wait_wdata();
      test_fifo_full();
      test_mask();
      test_back_to_back();
      test_reset_midop();
      test_illegal();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
